ntt_loader: RTL and testbench

//  Coefficient load/unload front end for the NTT core. Streams N input coefficients into the four

---
 rtl/ntt_loader.sv | 181 ++++++++++++++++++
 tb/tb_ntt_loader.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_loader.sv
// Load/unload front end for the NTT core: streams N coefficients into four interleaved
// RAM banks, kicks the transform, then streams the results back out in natural order.
module ntt_loader #(
  parameter int N  = 256,
  parameter int DW = 16,
  parameter int AW = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_start,
  input  logic [DW-1:0]   in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic            start,
  output logic            valid,
  input  logic            ntt_done,
  output logic [3:0]      ram_en,
  output logic [3:0]      ram_we,
  output logic [AW-1:0]   ram_addr,
  output logic [DW-1:0]   ram_din,
  input  logic [4*DW-1:0] ram_dout,
  output logic [DW-1:0]   out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            busy,
  output logic [2:0]      dbg_state
);

  // Handshakes (in_* and out_*): a word moves on a rising edge where valid and ready are
  // both high; neither valid nor ready depends combinationally on the other side's signal.

  localparam int CW = AW + 2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_KICK   = 3'd2,
    S_WAIT   = 3'd3,
    S_UNLOAD = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   wr_cnt_q, wr_cnt_d;
  logic [CW-1:0]   rd_cnt_q, rd_cnt_d;
  logic            rd_done_q, rd_done_d;
  logic            inflight_q, inflight_d;
  logic [1:0]      rd_bank_q, rd_bank_d;
  logic [DW-1:0]   fifo_q [2];
  logic [DW-1:0]   fifo_d [2];
  logic            fifo_head_q, fifo_head_d;
  logic [1:0]      fifo_cnt_q, fifo_cnt_d;

  logic            wr_fire;
  logic            rd_fire;
  logic            pop;
  logic            push;
  logic [2:0]      occ;
  logic [DW-1:0]   push_data;
  logic            wr_idx;

  always_comb begin
    state_d     = state_q;
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    rd_done_d   = rd_done_q;
    rd_bank_d   = rd_bank_q;
    fifo_d[0]   = fifo_q[0];
    fifo_d[1]   = fifo_q[1];
    ram_en      = 4'b0000;
    ram_we      = 4'b0000;
    ram_addr    = '0;
    ram_din     = '0;
    start       = 1'b0;
    valid       = 1'b0;
    push_data   = '0;

    in_ready    = (state_q == S_LOAD);
    wr_fire     = in_ready & in_valid;
    out_valid   = (fifo_cnt_q != 2'd0);
    out_data    = fifo_q[fifo_head_q];
    pop         = out_valid & out_ready;
    // Words already buffered or on their way back; a slot freed by this cycle's pop counts.
    occ         = {1'b0, fifo_cnt_q} + {2'b00, inflight_q};
    rd_fire     = (state_q == S_UNLOAD) && !rd_done_q && (occ < (3'd2 + {2'b00, pop}));
    inflight_d  = rd_fire;
    push        = inflight_q;

    for (int b = 0; b < 4; b++) begin
      if (rd_bank_q == 2'(b)) push_data = ram_dout[b*DW +: DW];
    end

    case (state_q)
      S_IDLE: begin
        if (load_start) begin
          state_d  = S_LOAD;
          wr_cnt_d = '0;
        end
      end
      S_LOAD: begin
        if (wr_fire) begin
          ram_en   = 4'b0001 << wr_cnt_q[1:0];
          ram_we   = 4'b0001 << wr_cnt_q[1:0];
          ram_addr = wr_cnt_q[CW-1:2];
          ram_din  = in_data;
          wr_cnt_d = wr_cnt_q + 1'b1;
          if (wr_cnt_q == CW'(N - 1)) begin
            state_d  = S_KICK;
            wr_cnt_d = '0;
          end
        end
      end
      S_KICK: begin
        start   = 1'b1;
        valid   = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        valid = 1'b1;
        if (ntt_done) begin
          state_d   = S_UNLOAD;
          rd_cnt_d  = '0;
          rd_done_d = 1'b0;
        end
      end
      S_UNLOAD: begin
        if (rd_fire) begin
          ram_en    = 4'b0001 << rd_cnt_q[1:0];
          ram_addr  = rd_cnt_q[CW-1:2];
          rd_bank_d = rd_cnt_q[1:0];
          rd_cnt_d  = rd_cnt_q + 1'b1;
          if (rd_cnt_q == CW'(N - 1)) begin
            rd_done_d = 1'b1;
            rd_cnt_d  = '0;
          end
        end
        // Last word leaves the FIFO with nothing else outstanding.
        if (pop && rd_done_q && !inflight_q && (fifo_cnt_q == 2'd1)) begin
          state_d   = S_IDLE;
          rd_done_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Slot after the head is free whenever count < 2, or the head itself if it pops while full.
    wr_idx = fifo_head_q ^ fifo_cnt_q[0];
    if (push) fifo_d[wr_idx] = push_data;
    fifo_head_d = fifo_head_q ^ pop;
    fifo_cnt_d  = fifo_cnt_q + {1'b0, push} - {1'b0, pop};

    busy      = (state_q != S_IDLE);
    dbg_state = state_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      rd_done_q   <= 1'b0;
      inflight_q  <= 1'b0;
      rd_bank_q   <= 2'b00;
      fifo_q[0]   <= '0;
      fifo_q[1]   <= '0;
      fifo_head_q <= 1'b0;
      fifo_cnt_q  <= 2'b00;
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      rd_done_q   <= rd_done_d;
      inflight_q  <= inflight_d;
      rd_bank_q   <= rd_bank_d;
      fifo_q[0]   <= fifo_d[0];
      fifo_q[1]   <= fifo_d[1];
      fifo_head_q <= fifo_head_d;
      fifo_cnt_q  <= fifo_cnt_d;
    end
  end

endmodule

// File: tb/tb_ntt_loader.sv
// Bench for ntt_loader: a table of IDLE/LOAD command vectors, then full load/kick/unload
// passes with held, toggling and random handshakes, checked against a phase-level model.
module tb_ntt_loader;

  localparam int N  = 256;
  localparam int DW = 16;
  localparam int AW = 6;

  logic            clk;
  logic            rst;
  logic            load_start;
  logic [DW-1:0]   in_data;
  logic            in_valid;
  logic            in_ready;
  logic            start;
  logic            valid;
  logic            ntt_done;
  logic [3:0]      ram_en;
  logic [3:0]      ram_we;
  logic [AW-1:0]   ram_addr;
  logic [DW-1:0]   ram_din;
  logic [4*DW-1:0] ram_dout;
  logic [DW-1:0]   out_data;
  logic            out_valid;
  logic            out_ready;
  logic            busy;
  logic [2:0]      dbg_state;

  ntt_loader #(.N(N), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .load_start(load_start),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .start(start), .valid(valid), .ntt_done(ntt_done),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- RAM bank model ----------------
  logic [DW-1:0] ram_m [4][N/4];
  logic [DW-1:0] ram_rd [4];
  logic [DW-1:0] preset_v [N];
  logic          do_preset;

  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (ram_en[b] && ram_we[b])  ram_m[b][ram_addr] <= ram_din;
      if (ram_en[b] && !ram_we[b]) ram_rd[b] <= ram_m[b][ram_addr];
    end
    if (do_preset) begin
      for (int k = 0; k < N; k++) ram_m[k%4][k/4] <= preset_v[k];
    end
  end
  assign ram_dout = {ram_rd[3], ram_rd[2], ram_rd[1], ram_rd[0]};

  // ---------------- scoreboard / model ----------------
  int total = 0;
  int bad   = 0;
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] coeff [N];
  int m_ph;   // 0 idle, 1 load, 2 kick, 3 wait, 4 unload
  int m_k;    // words accepted this load
  int m_rd;   // reads issued this unload
  int m_pop;  // words delivered this unload
  logic cont_chk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ph = 0; m_k = 0; m_rd = 0; m_pop = 0;
    exp_q.delete();
  endtask

  // One clock: drive at negedge, check at negedge+1, advance the model.
  task automatic step(input logic ld, input logic iv, input logic dn, input logic ordy);
    logic acc;
    logic [DW-1:0] din;
    @(negedge clk);
    din = (m_k < N) ? coeff[m_k] : DW'($urandom);
    load_start = ld; in_valid = iv; in_data = din; ntt_done = dn; out_ready = ordy;
    #1;
    chk("busy", busy, m_ph != 0);
    chk("in_ready", in_ready, m_ph == 1);
    chk("start", start, m_ph == 2);
    chk("valid", valid, (m_ph == 2) || (m_ph == 3));
    acc = iv && (m_ph == 1);
    if (acc) begin
      chk("wr_en", ram_en, 4'b0001 << (m_k % 4));
      chk("wr_we", ram_we, 4'b0001 << (m_k % 4));
      chk("wr_addr", ram_addr, m_k / 4);
      chk("wr_din", ram_din, din);
    end else if (m_ph == 4) begin
      chk("rd_we", ram_we, 0);
      if (ram_en != 4'b0000) begin
        chk("rd_en", ram_en, 4'b0001 << (m_rd % 4));
        chk("rd_addr", ram_addr, m_rd / 4);
        chk("rd_in_range", m_rd < N, 1);
        m_rd++;
      end
    end else begin
      chk("port_idle", {ram_en, ram_we}, 0);
    end
    if (m_ph == 4) begin
      if (cont_chk && m_pop > 0 && m_pop < N) chk("out_cont", out_valid, 1);
      if (out_valid && ordy) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL out_extra: got word %0h expected none", out_data);
        end else begin
          chk("out_data", out_data, exp_q.pop_front());
        end
        m_pop++;
      end
      chk("outstanding", (m_rd - m_pop) <= 2, 1);
    end else begin
      chk("out_valid", out_valid, 0);
    end
    case (m_ph)
      0: if (ld) begin m_ph = 1; m_k = 0; end
      1: if (acc) begin m_k++; if (m_k == N) m_ph = 2; end
      2: m_ph = 3;
      3: if (dn) begin m_ph = 4; m_rd = 0; m_pop = 0; end
      4: if (m_pop == N) m_ph = 0;
      default: m_ph = 0;
    endcase
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_ram_en"}, ram_en, 0);
    chk({tag, "_ram_we"}, ram_we, 0);
    chk({tag, "_start"}, start, 0);
    chk({tag, "_valid"}, valid, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_out_data"}, out_data, 0);
  endtask

  // Called right after a step: asserts rst between edges and checks outputs drop at once.
  task automatic reset_mid(input string tag);
    #2;
    rst = 1'b1;
    #1;
    chk_outputs_zero(tag);
    load_start = 0; in_valid = 0; ntt_done = 0; out_ready = 0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // mode 0: in_valid held, 1: toggling 1010.., 2: random
  task automatic load_all(input int mode);
    int cyc;
    logic iv;
    cyc = 0;
    while (m_ph == 1 && cyc < 4*N) begin
      iv = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc % 2) == 0) : 1'($urandom_range(0, 1));
      step($urandom_range(0, 15) == 0, iv, $urandom_range(0, 15) == 0, 1'b0);
      cyc++;
    end
    chk("load_timeout", m_ph == 1, 0);
  endtask

  task automatic check_ram();
    for (int k = 0; k < N; k++) chk("ram_contents", ram_m[k%4][k/4], coeff[k]);
  endtask

  // Kick, wait, preset RAM with result values, pulse ntt_done, unload until done or stop_pop.
  task automatic finish_run(input int rdy_mode, input int stop_pop);
    int cyc;
    logic ordy;
    step(0, 0, 0, 0);           // KICK cycle
    check_ram();
    step(1, 0, 0, 0);           // load_start in WAIT is ignored
    step(0, 1, 0, 0);
    for (int k = 0; k < N; k++) begin
      preset_v[k] = DW'($urandom);
      exp_q.push_back(preset_v[k]);
    end
    do_preset = 1'b1;
    step(0, 0, 0, 0);
    do_preset = 1'b0;
    step(0, 0, 1, 0);           // ntt_done
    cyc = 0;
    while (m_ph == 4 && m_pop < stop_pop && cyc < 8*N) begin
      ordy = (rdy_mode == 0) ? 1'b1 : ($urandom_range(0, 99) < 30);
      step($urandom_range(0, 15) == 0, 1'b0, 1'b0, ordy);
      cyc++;
    end
    chk("unload_timeout", cyc < 8*N, 1);
  endtask

  // ---------------- table vectors for IDLE/LOAD command handling ----------------
  typedef struct {
    logic ld, iv, dn;
    logic e_busy, e_inr, e_valid, e_start;
  } vec_t;
  vec_t tbl [6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{0, 0, 1, 0, 0, 0, 0};
    tbl[1] = '{0, 1, 1, 0, 0, 0, 0};
    tbl[2] = '{0, 1, 0, 0, 0, 0, 0};
    tbl[3] = '{1, 0, 0, 0, 0, 0, 0};
    tbl[4] = '{1, 0, 1, 1, 1, 0, 0};
    tbl[5] = '{0, 0, 1, 1, 1, 0, 0};

    rst = 1'b1; load_start = 0; in_valid = 0; in_data = '0;
    ntt_done = 0; out_ready = 0; do_preset = 1'b0; cont_chk = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk_outputs_zero("reset");
    rst = 1'b0;

    // Command pulses in IDLE and LOAD, then test 1: ramp 0..N-1 with in_valid held.
    for (int k = 0; k < N; k++) coeff[k] = DW'(k);
    for (int i = 0; i < 6; i++) begin
      step(tbl[i].ld, tbl[i].iv, tbl[i].dn, 1'b0);
      chk("tbl_busy", busy, tbl[i].e_busy);
      chk("tbl_in_ready", in_ready, tbl[i].e_inr);
      chk("tbl_valid", valid, tbl[i].e_valid);
      chk("tbl_start", start, tbl[i].e_start);
    end
    load_all(0);
    cont_chk = 1'b1;
    finish_run(0, N + 1);
    cont_chk = 1'b0;
    step(0, 0, 0, 0);
    chk("idle_after_unload", busy, 0);

    // Test 2/4: toggling in_valid, random 30% out_ready.
    for (int k = 0; k < N; k++) coeff[k] = DW'($urandom);
    step(1, 0, 0, 0);
    load_all(1);
    finish_run(1, N + 1);
    step(0, 0, 0, 0);

    // Test 6: reset at k=100 of a load, and again mid-unload, then a clean full pass.
    for (int k = 0; k < N; k++) coeff[k] = DW'($urandom);
    step(1, 0, 0, 0);
    while (m_ph == 1 && m_k < 100) step(0, 1, 0, 0);
    reset_mid("rst_load");
    step(0, 0, 0, 0);
    for (int k = 0; k < N; k++) coeff[k] = DW'($urandom);
    step(1, 0, 0, 0);
    load_all(2);
    finish_run(1, 60);
    reset_mid("rst_unload");
    for (int k = 0; k < N; k++) coeff[k] = DW'($urandom);
    step(1, 0, 0, 0);
    load_all(2);
    finish_run(1, N + 1);
    step(0, 0, 0, 0);
    chk("final_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
